// File: rtl/vga_scan_pkg.sv
// Shared timing defaults and elaboration helpers for the VGA scan controller.
package vga_scan_pkg;

  // 640x480@60 defaults (25.175 MHz pixel clock)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Total clocks per line, or total lines per frame.
  function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Framebuffer read port plus DAC-side outputs of the scan controller.
interface vga_scan_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] oRD_ADDR;
  logic              oRD_EN;
  logic [23:0]       iPIX;      // {b, g, r}
  logic [7:0]        r_data;
  logic [7:0]        g_data;
  logic [7:0]        b_data;
  logic              oBLANK_n;
  logic              oHS;
  logic              oVS;

  modport master (
    output oRD_ADDR, oRD_EN, r_data, g_data, b_data, oBLANK_n, oHS, oVS,
    input  iPIX
  );

  modport slave (
    input  oRD_ADDR, oRD_EN, r_data, g_data, b_data, oBLANK_n, oHS, oVS,
    output iPIX
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; reset loads RST_VAL into every stage so the
// outputs come out of reset already at their idle (inactive) levels.
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stage_d[gi] = din;
    end else begin : g_tail
      assign stage_d[gi] = stage_q[gi-1];
    end
  end

  // Shift every stage each clock; synchronous reset to the idle pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster timing generator with framebuffer address/strobe generation,
// pixel replication, double-buffered frame base and read-latency alignment.
module vga_scan_ctrl
  import vga_scan_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int ADDR_W     = 19,
  parameter int RD_LAT     = 2,
  parameter int SCALE_LOG2 = 0,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iEN,
  input  logic [ADDR_W-1:0] iBASE_ADDR,
  output logic              oFRAME_DONE,
  vga_scan_ctrl_if.master   bus
);
  localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  // One spare bit so the sync end bound never aliases to zero.
  localparam int HW = clog2(H_TOTAL + 1);
  localparam int VW = clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_LOG2);
  localparam logic [VW-1:0]     REP_MASK  = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [2:0]        DL_IDLE   = {1'b0, ~HS_POL, ~VS_POL};

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] shadow_q, shadow_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              rd_en_q, rd_en_d;
  logic              frame_done_q, frame_done_d;
  logic              blank_n_q, blank_n_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;

  logic       h_wrap, v_wrap, frame_edge;
  logic       vis, hs_raw, vs_raw;
  logic [2:0] dl_in, dl_out;

  assign h_wrap     = (h_q == H_LAST);
  assign v_wrap     = (v_q == V_LAST);
  assign frame_edge = iEN && (h_q == '0) && (v_q == V_VIS);

  assign vis    = iEN && (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_raw = iEN && (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_raw = iEN && (v_q >= VS_BEG) && (v_q < VS_END);

  // Sync levels enter the delay line already polarity-encoded.
  assign dl_in = {vis, hs_raw ? HS_POL : ~HS_POL, vs_raw ? VS_POL : ~VS_POL};

  // vis/hs/vs delayed to the cycle iPIX for that pixel is valid; the output
  // registers below add the final stage so blank/sync land with the colour.
  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (RD_LAT + 1),
    .RST_VAL(DL_IDLE)
  ) u_align (
    .clk  (iVGA_CLK),
    .rst_n(iRST_n),
    .din  (dl_in),
    .dout (dl_out)
  );

  // Next-state: counters, incremental addressing, base double-buffering, outputs.
  always_comb begin
    h_d          = h_q;
    v_d          = v_q;
    line_addr_d  = line_addr_q;
    shadow_d     = iBASE_ADDR;
    base_d       = base_q;
    frame_done_d = frame_edge;
    rd_en_d      = vis;
    // Column offset uses the counter directly, so a pixel address repeats
    // for 2^SCALE_LOG2 clocks without a separate pixel counter.
    rd_addr_d    = line_addr_q + ADDR_W'(h_q >> SCALE_LOG2);

    if (!iEN) begin
      h_d         = '0;
      v_d         = '0;
      line_addr_d = base_q;
    end else if (h_wrap) begin
      h_d = '0;
      if (v_wrap) begin
        v_d         = '0;
        line_addr_d = base_q;
      end else begin
        v_d = v_q + VW'(1);
        if (((v_q + VW'(1)) & REP_MASK) == '0) begin
          line_addr_d = line_addr_q + LINE_STEP;
        end
      end
    end else begin
      h_d = h_q + HW'(1);
    end

    // New base takes effect only at the next frame start (line_addr reload).
    if (frame_edge) begin
      base_d = shadow_q;
    end

    blank_n_d = dl_out[2];
    hs_d      = dl_out[1];
    vs_d      = dl_out[0];
    r_d       = dl_out[2] ? bus.iPIX[7:0]   : 8'h00;
    g_d       = dl_out[2] ? bus.iPIX[15:8]  : 8'h00;
    b_d       = dl_out[2] ? bus.iPIX[23:16] : 8'h00;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      h_q          <= '0;
      v_q          <= '0;
      line_addr_q  <= '0;
      rd_addr_q    <= '0;
      shadow_q     <= '0;
      base_q       <= '0;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      blank_n_q    <= 1'b0;
      hs_q         <= ~HS_POL;
      vs_q         <= ~VS_POL;
      r_q          <= 8'h00;
      g_q          <= 8'h00;
      b_q          <= 8'h00;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      line_addr_q  <= line_addr_d;
      rd_addr_q    <= rd_addr_d;
      shadow_q     <= shadow_d;
      base_q       <= base_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
      blank_n_q    <= blank_n_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
    end
  end

  assign bus.oRD_ADDR = rd_addr_q;
  assign bus.oRD_EN   = rd_en_q;
  assign bus.oBLANK_n = blank_n_q;
  assign bus.oHS      = hs_q;
  assign bus.oVS      = vs_q;
  assign bus.r_data   = r_q;
  assign bus.g_data   = g_q;
  assign bus.b_data   = b_q;
  assign oFRAME_DONE  = frame_done_q;
endmodule
